// File: rtl/jump_step_sequencer.sv
// jump_step_sequencer: Moore T-step control sequencer for the Mini SRC datapath
//    (fetch, br, jr, jal, nop, halt, illegal-opcode trap).
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_req; one instruction per pulse).
// Ports:
//    clk, clr (async active-low), run, [step_req], ir, con_ff  -- inputs
//    step                          -- present state encoding
//    pc_out .. link_in             -- datapath strobes, decoded from state
//    link_sel                      -- constant LINK_REG
//    alu_control                   -- ADD in T5, else 0
//    busy, halted, illegal         -- status
//    instr_count                   -- retired instruction counter (wraps)
module jump_step_sequencer #(
   parameter int IR_W     = 32,
   parameter int MEM_WAIT = 1,
   parameter int LINK_REG = 15,
   parameter int CNT_W    = 16
)(
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic             step_req,
`endif
   input  logic [IR_W-1:0]  ir,
   input  logic             con_ff,
   output logic [3:0]       step,
   output logic             pc_out,
   output logic             inc_pc,
   output logic             pc_en,
   output logic             mar_en,
   output logic             read,
   output logic             mdr_en,
   output logic             mdr_out,
   output logic             ir_en,
   output logic             gra,
   output logic             rout,
   output logic             con_in,
   output logic             y_en,
   output logic             c_out,
   output logic             z_en,
   output logic             zlo_out,
   output logic             link_in,
   output logic [3:0]       link_sel,
   output logic [4:0]       alu_control,
   output logic             busy,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [3:0] {
      IDLE = 4'b0000, T0 = 4'b0111, T1 = 4'b1000, T2 = 4'b1001, T3 = 4'b1010,
      T4 = 4'b1011, T5 = 4'b1100, T6 = 4'b1101, HALT = 4'b1111
   } state_t;
   localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10011, OP_JAL = 5'b10100;
   localparam logic [4:0] OP_NOP = 5'b11001, OP_HALT = 5'b11010;
   localparam int WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
   localparam logic [WW-1:0] WLAST = WW'(MEM_WAIT - 1);
   state_t state, nxt;
   logic [WW-1:0] wcnt;
   logic [4:0] op;
   logic is_br, is_jr, is_jal, bad_op, retire, start, cont;
   logic unused_ir;
   assign op        = ir[IR_W-1 -: 5];
   assign unused_ir = ^ir[IR_W-6:0];
   assign is_br     = op == OP_BR;
   assign is_jr     = op == OP_JR;
   assign is_jal    = op == OP_JAL;
   assign bad_op    = !(is_br || is_jr || is_jal || op == OP_NOP || op == OP_HALT);
`ifdef SEQ_SINGLE_STEP_EN
   assign start = run && step_req;
   assign cont  = 1'b0;
`else
   assign start = run;
   assign cont  = run;
`endif
   // jr/nop/illegal finish in T3, jal in T4, br in T6; halt never retires
   assign retire = (state == T3 && !is_br && !is_jal && op != OP_HALT) ||
                   (state == T4 && is_jal) || state == T6;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? T0 : IDLE;
         T0:      nxt = T1;
         T1:      nxt = (wcnt == WLAST) ? T2 : T1;
         T2:      nxt = T3;
         T3:      nxt = (op == OP_HALT) ? HALT : (is_br || is_jal) ? T4 : T3;
         T4:      nxt = T5;
         T5:      nxt = T6;
         T6:      nxt = T6;
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
      if (retire) nxt = cont ? T0 : IDLE;
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state       <= IDLE;
         wcnt        <= '0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= nxt;
         wcnt  <= (state == T1 && wcnt != WLAST) ? wcnt + 1'b1 : '0;
         if (state == T0) illegal <= 1'b0;
         else if (state == T3 && bad_op) illegal <= 1'b1;
         if (retire) instr_count <= instr_count + 1'b1;
      end
   end
   assign step        = state;
   assign pc_out      = state == T0 || (state == T3 && is_jal) || (state == T4 && !is_jal);
   assign inc_pc      = state == T0;
   assign mar_en      = state == T0;
   assign read        = state == T1;
   assign mdr_en      = state == T1;
   assign mdr_out     = state == T2;
   assign ir_en       = state == T2;
   assign gra         = (state == T3 && (is_br || is_jr)) || (state == T4 && is_jal);
   assign rout        = gra;
   assign con_in      = state == T3 && is_br;
   // the only Mealy path: branch-taken gating in T6
   assign pc_en       = (state == T3 && is_jr) || (state == T4 && is_jal) || (state == T6 && con_ff);
   assign link_in     = state == T3 && is_jal;
   assign y_en        = state == T4 && !is_jal;
   assign c_out       = state == T5;
   assign z_en        = state == T5;
   assign alu_control = (state == T5) ? 5'b00011 : 5'b00000;
   assign zlo_out     = state == T6;
   assign link_sel    = 4'(LINK_REG);
   assign busy        = state != IDLE && state != HALT;
   assign halted      = state == HALT;
endmodule

// File: tb/tb_jump_step_sequencer.sv
// tb_jump_step_sequencer: randomized self-checking bench; two DUTs (MEM_WAIT 1 and 3) share stimulus.
module tb_jump_step_sequencer;
   localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10011, OP_JAL = 5'b10100;
   localparam logic [4:0] OP_NOP = 5'b11001, OP_HALT = 5'b11010;
   localparam logic [15:0] PC_OUT = 16'h8000, INC_PC = 16'h4000, PC_EN = 16'h2000, MAR_EN = 16'h1000;
   localparam logic [15:0] READ = 16'h0800, MDR_EN = 16'h0400, MDR_OUT = 16'h0200, IR_EN = 16'h0100;
   localparam logic [15:0] GRA = 16'h0080, ROUT = 16'h0040, CON_IN = 16'h0020, Y_EN = 16'h0010;
   localparam logic [15:0] C_OUT = 16'h0008, Z_EN = 16'h0004, ZLO_OUT = 16'h0002, LINK_IN = 16'h0001;
   localparam int MWA = 1, MWB = 3, CMA = 65535, CMB = 7;
   logic clk = 0, clr = 0, run = 0, con_ff = 0, step_req = 0;
   logic [31:0] ir = '0;
   logic [3:0] step_a, step_b, ls_a, ls_b;
   logic [4:0] alu_a, alu_b;
   logic [15:0] cnt_a;
   logic [2:0] cnt_b;
   logic pco_a, inc_a, pce_a, mar_a, rd_a, mdr_a, mdo_a, ire_a, gra_a, rout_a, ci_a, y_a, co_a, z_a, zlo_a, li_a;
   logic pco_b, inc_b, pce_b, mar_b, rd_b, mdr_b, mdo_b, ire_b, gra_b, rout_b, ci_b, y_b, co_b, z_b, zlo_b, li_b;
   logic busy_a, busy_b, hlt_a, hlt_b, ill_a, ill_b;
   logic [26:0] w_a, w_b;
   int tests = 0, fails = 0;
   int mcnt_a = 0, mcnt_b = 0;
   logic mill_a = 0, mill_b = 0;
   always #5 clk = ~clk;
   assign w_a = {step_a, pco_a, inc_a, pce_a, mar_a, rd_a, mdr_a, mdo_a, ire_a,
                 gra_a, rout_a, ci_a, y_a, co_a, z_a, zlo_a, li_a, alu_a, busy_a, hlt_a};
   assign w_b = {step_b, pco_b, inc_b, pce_b, mar_b, rd_b, mdr_b, mdo_b, ire_b,
                 gra_b, rout_b, ci_b, y_b, co_b, z_b, zlo_b, li_b, alu_b, busy_b, hlt_b};
   jump_step_sequencer #(.IR_W(32), .MEM_WAIT(MWA), .LINK_REG(15), .CNT_W(16)) dut_a (
      .clk(clk), .clr(clr), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
      .step_req(step_req),
`endif
      .ir(ir), .con_ff(con_ff), .step(step_a),
      .pc_out(pco_a), .inc_pc(inc_a), .pc_en(pce_a), .mar_en(mar_a), .read(rd_a), .mdr_en(mdr_a),
      .mdr_out(mdo_a), .ir_en(ire_a), .gra(gra_a), .rout(rout_a), .con_in(ci_a), .y_en(y_a),
      .c_out(co_a), .z_en(z_a), .zlo_out(zlo_a), .link_in(li_a), .link_sel(ls_a), .alu_control(alu_a),
      .busy(busy_a), .halted(hlt_a), .illegal(ill_a), .instr_count(cnt_a));
   jump_step_sequencer #(.IR_W(32), .MEM_WAIT(MWB), .LINK_REG(5), .CNT_W(3)) dut_b (
      .clk(clk), .clr(clr), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
      .step_req(step_req),
`endif
      .ir(ir), .con_ff(con_ff), .step(step_b),
      .pc_out(pco_b), .inc_pc(inc_b), .pc_en(pce_b), .mar_en(mar_b), .read(rd_b), .mdr_en(mdr_b),
      .mdr_out(mdo_b), .ir_en(ire_b), .gra(gra_b), .rout(rout_b), .con_in(ci_b), .y_en(y_b),
      .c_out(co_b), .z_en(z_b), .zlo_out(zlo_b), .link_in(li_b), .link_sel(ls_b), .alu_control(alu_b),
      .busy(busy_b), .halted(hlt_b), .illegal(ill_b), .instr_count(cnt_b));
   function automatic logic [26:0] mk(logic [3:0] s, logic [15:0] st, logic [4:0] alu);
      return {s, st, alu, 1'b1, 1'b0};
   endfunction
   function automatic logic is_bad(logic [4:0] op);
      return !(op == OP_BR || op == OP_JR || op == OP_JAL || op == OP_NOP || op == OP_HALT);
   endfunction
   function automatic int len_of(int mw, logic [4:0] op);
      return 2 + mw + ((op == OP_BR) ? 4 : (op == OP_JAL) ? 2 : 1);
   endfunction
   // expected control word of cycle c counted from the first T0 of one instruction
   function automatic logic [26:0] exp_at(int mw, logic [4:0] op, logic cf, int c);
      logic [26:0] q[$];
      q.push_back(mk(4'h7, PC_OUT | MAR_EN | INC_PC, 5'd0));
      for (int i = 0; i < mw; i++) q.push_back(mk(4'h8, READ | MDR_EN, 5'd0));
      q.push_back(mk(4'h9, MDR_OUT | IR_EN, 5'd0));
      if (op == OP_BR) begin
         q.push_back(mk(4'hA, GRA | ROUT | CON_IN, 5'd0));
         q.push_back(mk(4'hB, PC_OUT | Y_EN, 5'd0));
         q.push_back(mk(4'hC, C_OUT | Z_EN, 5'b00011));
         q.push_back(mk(4'hD, ZLO_OUT | (cf ? PC_EN : 16'h0), 5'd0));
      end else if (op == OP_JR) q.push_back(mk(4'hA, GRA | ROUT | PC_EN, 5'd0));
      else if (op == OP_JAL) begin
         q.push_back(mk(4'hA, PC_OUT | LINK_IN, 5'd0));
         q.push_back(mk(4'hB, GRA | ROUT | PC_EN, 5'd0));
      end else q.push_back(mk(4'hA, 16'h0, 5'd0));
      if (c < q.size()) return q[c];
      return (op == OP_HALT) ? {4'hF, 16'h0, 5'h0, 1'b0, 1'b1} : 27'h0;
   endfunction
   task automatic pulse_reset();
      run = 0;
      clr = 0;
      @(posedge clk);
      @(posedge clk);
      #1 clr = 1;
      mcnt_a = 0; mcnt_b = 0; mill_a = 0; mill_b = 0;
      @(negedge clk);
   endtask
   // one instruction from IDLE with run pulsed for a single edge; checks every cycle of both DUTs
   task automatic exec_instr(input logic [31:0] instr, input logic cf, input string name);
      logic [4:0] op;
      int la, lb, ea, eb;
      logic [26:0] xa, xb;
      logic ia, ib;
      op = instr[31:27];
      la = len_of(MWA, op);
      lb = len_of(MWB, op);
      ir = instr; con_ff = cf; run = 1;
      for (int c = 0; c < lb + 2; c++) begin
         @(posedge clk);
         #1 run = 0;
         @(negedge clk);
         xa = exp_at(MWA, op, cf, c);
         xb = exp_at(MWB, op, cf, c);
         ea = (mcnt_a + ((c >= la && op != OP_HALT) ? 1 : 0)) & CMA;
         eb = (mcnt_b + ((c >= lb && op != OP_HALT) ? 1 : 0)) & CMB;
         ia = (c == 0) ? mill_a : (c >= la) && is_bad(op);
         ib = (c == 0) ? mill_b : (c >= lb) && is_bad(op);
         tests += 6;
         if (w_a !== xa) begin fails++; $display("FAIL %s word A cyc=%0d got=%h exp=%h", name, c, w_a, xa); end
         if (w_b !== xb) begin fails++; $display("FAIL %s word B cyc=%0d got=%h exp=%h", name, c, w_b, xb); end
         if (cnt_a !== 16'(ea)) begin fails++; $display("FAIL %s count A cyc=%0d got=%0d exp=%0d", name, c, cnt_a, ea); end
         if (cnt_b !== 3'(eb)) begin fails++; $display("FAIL %s count B cyc=%0d got=%0d exp=%0d", name, c, cnt_b, eb); end
         if (ill_a !== ia) begin fails++; $display("FAIL %s illegal A cyc=%0d got=%b exp=%b", name, c, ill_a, ia); end
         if (ill_b !== ib) begin fails++; $display("FAIL %s illegal B cyc=%0d got=%b exp=%b", name, c, ill_b, ib); end
      end
      if (op != OP_HALT) begin
         mcnt_a = (mcnt_a + 1) & CMA;
         mcnt_b = (mcnt_b + 1) & CMB;
      end
      mill_a = is_bad(op);
      mill_b = is_bad(op);
   endtask
   task automatic test_reset();
      clr = 0;
      #12;
      tests += 5;
      if (w_a !== 27'h0 || w_b !== 27'h0) begin fails++; $display("FAIL reset words got=%h/%h exp=0", w_a, w_b); end
      if (ls_a !== 4'd15) begin fails++; $display("FAIL reset link_sel A got=%0d exp=15", ls_a); end
      if (ls_b !== 4'd5) begin fails++; $display("FAIL reset link_sel B got=%0d exp=5", ls_b); end
      if (cnt_a !== 16'd0 || cnt_b !== 3'd0) begin fails++; $display("FAIL reset count got=%0d/%0d exp=0", cnt_a, cnt_b); end
      if (ill_a !== 1'b0 || ill_b !== 1'b0) begin fails++; $display("FAIL reset illegal got=%b/%b exp=0", ill_a, ill_b); end
      pulse_reset();
   endtask
   task automatic test_jr();
      exec_instr(32'h98000000, 1'b0, "jr");
   endtask
   task automatic test_br();
      exec_instr(32'h90000000, 1'b1, "br_taken");
      exec_instr(32'h90000000, 1'b0, "br_not_taken");
   endtask
   task automatic test_jal();
      exec_instr(32'hA0000000, 1'b0, "jal");
      tests++;
      if (ls_a !== 4'd15) begin fails++; $display("FAIL jal link_sel got=%0d exp=15", ls_a); end
   endtask
   task automatic test_random();
      logic [4:0] op;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 4))
            0: op = OP_BR;
            1: op = OP_JR;
            2: op = OP_JAL;
            3: op = OP_NOP;
            default: begin
               op = 5'($urandom);
               while (!is_bad(op)) op = 5'($urandom);
            end
         endcase
         exec_instr({op, 27'($urandom)}, 1'($urandom), "random");
      end
   endtask
   task automatic test_back_to_back();
      logic [4:0] ops[3] = '{OP_JR, OP_BR, 5'b00000};
      for (int k = 0; k < 3; k++) begin
         logic [4:0] op;
         logic cf;
         int la, lb;
         op = ops[k];
         cf = 1'($urandom);
         la = len_of(MWA, op);
         lb = len_of(MWB, op);
         ir = {op, 27'($urandom)}; con_ff = cf; run = 1;
         for (int c = 0; c < 40; c++) begin
            logic [26:0] xa, xb;
            logic ia, ib;
            @(posedge clk);
            @(negedge clk);
            xa = exp_at(MWA, op, cf, c % la);
            xb = exp_at(MWB, op, cf, c % lb);
            ia = (c % la == 0) ? ((c == 0) ? mill_a : is_bad(op)) : 1'b0;
            ib = (c % lb == 0) ? ((c == 0) ? mill_b : is_bad(op)) : 1'b0;
            tests += 6;
            if (w_a !== xa) begin fails++; $display("FAIL b2b word A cyc=%0d got=%h exp=%h", c, w_a, xa); end
            if (w_b !== xb) begin fails++; $display("FAIL b2b word B cyc=%0d got=%h exp=%h", c, w_b, xb); end
            if (cnt_a !== 16'((mcnt_a + c / la) & CMA)) begin fails++; $display("FAIL b2b count A cyc=%0d got=%0d", c, cnt_a); end
            if (cnt_b !== 3'((mcnt_b + c / lb) & CMB)) begin fails++; $display("FAIL b2b count B cyc=%0d got=%0d", c, cnt_b); end
            if (ill_a !== ia) begin fails++; $display("FAIL b2b illegal A cyc=%0d got=%b exp=%b", c, ill_a, ia); end
            if (ill_b !== ib) begin fails++; $display("FAIL b2b illegal B cyc=%0d got=%b exp=%b", c, ill_b, ib); end
         end
         pulse_reset();
      end
   endtask
   task automatic test_reset_mid_br();
      ir = 32'h90000000; con_ff = 1; run = 1;
      @(posedge clk);
      #1 run = 0;
      for (int c = 1; c < 6; c++) @(posedge clk);
      @(negedge clk);
      tests++;
      if (step_a !== 4'hC) begin fails++; $display("FAIL midbr pre step got=%h exp=c", step_a); end
      clr = 0;
      #1;
      tests += 4;
      if (w_a !== 27'h0) begin fails++; $display("FAIL midbr word A got=%h exp=0", w_a); end
      if (w_b !== 27'h0) begin fails++; $display("FAIL midbr word B got=%h exp=0", w_b); end
      if (cnt_a !== 16'd0) begin fails++; $display("FAIL midbr count got=%0d exp=0", cnt_a); end
      if (ls_a !== 4'd15) begin fails++; $display("FAIL midbr link_sel got=%0d exp=15", ls_a); end
      pulse_reset();
   endtask
   task automatic test_halt_illegal();
      exec_instr(32'hD0000000, 1'b0, "halt");
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1 run = 1'($urandom);
         @(negedge clk);
         tests += 2;
         if (w_a !== {4'hF, 22'h0, 1'b1}) begin fails++; $display("FAIL halt hold A cyc=%0d got=%h", c, w_a); end
         if (w_b !== {4'hF, 22'h0, 1'b1}) begin fails++; $display("FAIL halt hold B cyc=%0d got=%h", c, w_b); end
      end
      pulse_reset();
      exec_instr(32'hF8000000, 1'b0, "illegal");
      exec_instr(32'hC8000000, 1'b0, "nop_after_illegal");
   endtask
   initial begin
      test_reset();
      test_jr();
      test_br();
      test_jal();
      test_random();
      test_back_to_back();
      test_reset_mid_br();
      test_halt_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
